// File: rtl/hold_pkg.sv
// Shared types and default constants for the hold-style gate/toggle receiver.
package hold_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2,
        HUNT  = 2'd3
    } hold_state_e;

    localparam int HOLD_CNT_W   = 4;
    localparam int HOLD_EXP_LEN = 5;

endpackage

// File: rtl/hold_tog_det.sv
// Registers the frame flag and flags any change against its previous value.
module hold_tog_det (
    input  logic clk,
    input  logic rst,
    input  logic i_f,
    output logic o_tg
);

    logic r_f_q;

    // NOTE: synchronous reset lives inside the clocked block, so rst is only sampled on clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_f_q <= 1'b0;
        end else begin
            r_f_q <= i_f;
        end
    end

    assign o_tg = i_f ^ r_f_q;

endmodule

// File: rtl/hold_rx.sv
// Receive side of the hold gate/toggle link: measures bursts, reports frames,
// protocol errors and a lock indication. All outputs are registered.
module hold_rx
    import hold_pkg::*;
#(
    parameter int CNT_W   = HOLD_CNT_W,
    parameter int EXP_LEN = HOLD_EXP_LEN,
    parameter int MAX_LEN = 15,
    parameter int LOCK_N  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             g_in,
    input  logic             f_in,
    output logic             frame_done,
    output logic [CNT_W-1:0] frame_len,
    output logic             len_err,
    output logic             toggle_err,
    output logic             gap_err,
    output logic             ovf_err,
    output logic [15:0]      frame_cnt,
    output logic             locked
);

    localparam int GOOD_W = (LOCK_N < 1) ? 1 : $clog2(LOCK_N + 1);

    hold_state_e       r_state;
    logic [CNT_W-1:0]  r_len_cnt;
    logic [GOOD_W-1:0] r_good_cnt;

    hold_state_e       w_state_nxt;
    logic [CNT_W-1:0]  w_len_nxt;
    logic [CNT_W-1:0]  w_len_inc;
    logic [GOOD_W-1:0] w_good_nxt;
    logic              w_tg;
    logic              w_done;
    logic              w_len_err;
    logic              w_tog_err;
    logic              w_gap_err;
    logic              w_ovf_err;
    logic              w_any_err;

    hold_tog_det u_tog_det (
        .clk  (clk),
        .rst  (rst),
        .i_f  (f_in),
        .o_tg (w_tg)
    );

    assign w_len_inc = r_len_cnt + CNT_W'(1);

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len_cnt;
        w_done      = 1'b0;
        w_len_err   = 1'b0;
        w_tog_err   = 1'b0;
        w_gap_err   = 1'b0;
        w_ovf_err   = 1'b0;
        case (r_state)
            IDLE: begin
                w_tog_err = w_tg;
                if (g_in) begin
                    w_state_nxt = BURST;
                    w_len_nxt   = CNT_W'(1);
                end
            end
            BURST: begin
                if (g_in) begin
                    w_len_nxt = w_len_inc;
                    w_tog_err = w_tg;
                    if (w_len_inc == CNT_W'(MAX_LEN)) begin
                        w_ovf_err   = 1'b1;
                        w_state_nxt = HUNT;
                    end
                end else if (w_tg) begin
                    w_done      = 1'b1;
                    w_len_err   = (r_len_cnt != CNT_W'(EXP_LEN));
                    w_state_nxt = GAP;
                end else begin
                    w_tog_err   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            GAP: begin
                w_tog_err = w_tg;
                if (g_in) begin
                    // Too-short gap is reported, but the new burst is still measured.
                    w_gap_err   = 1'b1;
                    w_state_nxt = BURST;
                    w_len_nxt   = CNT_W'(1);
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            HUNT: begin
                if (!g_in) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Any error pulse drops lock immediately; clean frames climb to LOCK_N and saturate.
    always_comb begin
        w_any_err  = w_len_err | w_tog_err | w_gap_err | w_ovf_err;
        w_good_nxt = r_good_cnt;
        if (w_any_err) begin
            w_good_nxt = '0;
        end else if (w_done && (r_good_cnt != GOOD_W'(LOCK_N))) begin
            w_good_nxt = r_good_cnt + GOOD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_len_cnt  <= '0;
            r_good_cnt <= '0;
            frame_done <= 1'b0;
            frame_len  <= '0;
            len_err    <= 1'b0;
            toggle_err <= 1'b0;
            gap_err    <= 1'b0;
            ovf_err    <= 1'b0;
            frame_cnt  <= '0;
            locked     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_len_cnt  <= w_len_nxt;
            r_good_cnt <= w_good_nxt;
            frame_done <= w_done;
            len_err    <= w_len_err;
            toggle_err <= w_tog_err;
            gap_err    <= w_gap_err;
            ovf_err    <= w_ovf_err;
            locked     <= (w_good_nxt == GOOD_W'(LOCK_N));
            if (w_done) begin
                frame_len <= r_len_cnt;
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_hold_rx.sv
// Directed bench for hold_rx: nominal frames, length errors, toggle/gap/overflow errors, reset.
module tb_hold_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        g_in;
    logic        f_in;
    logic        frame_done;
    logic [3:0]  frame_len;
    logic        len_err;
    logic        toggle_err;
    logic        gap_err;
    logic        ovf_err;
    logic [15:0] frame_cnt;
    logic        locked;

    int   checks = 0;
    int   errors = 0;
    logic f_lvl;
    int   exp_cnt;
    int   seen_done, seen_len, seen_tog, seen_gap, seen_ovf;

    hold_rx dut (
        .clk        (clk),
        .rst        (rst),
        .g_in       (g_in),
        .f_in       (f_in),
        .frame_done (frame_done),
        .frame_len  (frame_len),
        .len_err    (len_err),
        .toggle_err (toggle_err),
        .gap_err    (gap_err),
        .ovf_err    (ovf_err),
        .frame_cnt  (frame_cnt),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    // One input cycle; outputs it caused are sampled 1 time unit after the edge.
    task automatic step(input logic g, input logic f);
        @(negedge clk);
        g_in  = g;
        f_in  = f;
        f_lvl = f;
        @(posedge clk);
        #1;
        seen_done += int'(frame_done);
        seen_len  += int'(len_err);
        seen_tog  += int'(toggle_err);
        seen_gap  += int'(gap_err);
        seen_ovf  += int'(ovf_err);
    endtask

    task automatic high(input int n);
        repeat (n) step(1'b1, f_lvl);
    endtask

    task automatic toggle_low();
        step(1'b0, ~f_lvl);
    endtask

    task automatic clear_seen();
        seen_done = 0; seen_len = 0; seen_tog = 0; seen_gap = 0; seen_ovf = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; g_in = 1'b0; f_in = 1'b0; f_lvl = 1'b0;
        clear_seen();
        repeat (2) step(1'b0, 1'b0);
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %0b want 0", frame_done); end
        checks++; if (frame_len !== 4'd0) begin errors++; $display("FAIL reset_frame_len got %0d want 0", frame_len); end
        checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL reset_len_err got %0b want 0", len_err); end
        checks++; if (toggle_err !== 1'b0) begin errors++; $display("FAIL reset_toggle_err got %0b want 0", toggle_err); end
        checks++; if (gap_err !== 1'b0) begin errors++; $display("FAIL reset_gap_err got %0b want 0", gap_err); end
        checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL reset_ovf_err got %0b want 0", ovf_err); end
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %0b want 0", locked); end
        rst = 1'b0;
        exp_cnt = 0;
        step(1'b0, 1'b0);
    endtask

    task automatic test_nominal();
        clear_seen();
        for (int i = 0; i < 4; i++) begin
            high(5);
            toggle_low();
            exp_cnt++;
            checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL nom_done[%0d] got %0b want 1", i, frame_done); end
            checks++; if (frame_len !== 4'd5) begin errors++; $display("FAIL nom_len[%0d] got %0d want 5", i, frame_len); end
            checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL nom_len_err[%0d] got %0b want 0", i, len_err); end
            checks++; if (locked !== logic'(i >= 2)) begin errors++; $display("FAIL nom_locked[%0d] got %0b want %0b", i, locked, i >= 2); end
            step(1'b0, f_lvl);
        end
        checks++; if (frame_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL nom_frame_cnt got %0d want %0d", frame_cnt, exp_cnt); end
        checks++; if (seen_done != 4) begin errors++; $display("FAIL nom_done_pulses got %0d want 4", seen_done); end
        checks++; if (seen_len + seen_tog + seen_gap + seen_ovf != 0) begin
            errors++; $display("FAIL nom_err_pulses got %0d want 0", seen_len + seen_tog + seen_gap + seen_ovf);
        end
    endtask

    task automatic test_len_err();
        high(3);
        toggle_low();
        exp_cnt++;
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL len3_done got %0b want 1", frame_done); end
        checks++; if (frame_len !== 4'd3) begin errors++; $display("FAIL len3_len got %0d want 3", frame_len); end
        checks++; if (len_err !== 1'b1) begin errors++; $display("FAIL len3_len_err got %0b want 1", len_err); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL len3_locked got %0b want 0", locked); end
        step(1'b0, f_lvl);
        high(7);
        toggle_low();
        exp_cnt++;
        checks++; if (frame_len !== 4'd7) begin errors++; $display("FAIL len7_len got %0d want 7", frame_len); end
        checks++; if (len_err !== 1'b1) begin errors++; $display("FAIL len7_len_err got %0b want 1", len_err); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL len7_locked got %0b want 0", locked); end
        step(1'b0, f_lvl);
        checks++; if (frame_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL len_frame_cnt got %0d want %0d", frame_cnt, exp_cnt); end
    endtask

    task automatic lock_up(input string tag);
        repeat (3) begin
            high(5);
            toggle_low();
            exp_cnt++;
            step(1'b0, f_lvl);
        end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL %s_relock got %0b want 1", tag, locked); end
    endtask

    task automatic test_toggle_err();
        lock_up("idle_tog");
        toggle_low();
        checks++; if (toggle_err !== 1'b1) begin errors++; $display("FAIL idle_tog_err got %0b want 1", toggle_err); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL idle_tog_done got %0b want 0", frame_done); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL idle_tog_locked got %0b want 0", locked); end
        step(1'b0, f_lvl);
        lock_up("no_tog");
        high(5);
        step(1'b0, f_lvl);
        checks++; if (toggle_err !== 1'b1) begin errors++; $display("FAIL no_tog_err got %0b want 1", toggle_err); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL no_tog_done got %0b want 0", frame_done); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL no_tog_locked got %0b want 0", locked); end
        checks++; if (frame_len !== 4'd5) begin errors++; $display("FAIL no_tog_len_held got %0d want 5", frame_len); end
        step(1'b0, f_lvl);
        checks++; if (frame_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL tog_frame_cnt got %0d want %0d", frame_cnt, exp_cnt); end
    endtask

    task automatic test_overflow();
        clear_seen();
        high(14);
        checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL ovf_early got %0b want 0", ovf_err); end
        high(1);
        checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_at_15 got %0b want 1", ovf_err); end
        high(5);
        toggle_low();
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL ovf_fall_done got %0b want 0", frame_done); end
        checks++; if (toggle_err !== 1'b0) begin errors++; $display("FAIL ovf_fall_tog got %0b want 0", toggle_err); end
        step(1'b0, f_lvl);
        checks++; if (seen_ovf != 1) begin errors++; $display("FAIL ovf_pulses got %0d want 1", seen_ovf); end
        checks++; if (seen_done + seen_tog != 0) begin errors++; $display("FAIL ovf_other_pulses got %0d want 0", seen_done + seen_tog); end
        high(5);
        toggle_low();
        exp_cnt++;
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL post_ovf_done got %0b want 1", frame_done); end
        checks++; if (frame_len !== 4'd5) begin errors++; $display("FAIL post_ovf_len got %0d want 5", frame_len); end
        checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL post_ovf_len_err got %0b want 0", len_err); end
        step(1'b0, f_lvl);
    endtask

    task automatic test_gap_err();
        clear_seen();
        high(5);
        toggle_low();
        exp_cnt++;
        step(1'b1, f_lvl);
        checks++; if (gap_err !== 1'b1) begin errors++; $display("FAIL gap_err got %0b want 1", gap_err); end
        checks++; if (toggle_err !== 1'b0) begin errors++; $display("FAIL gap_tog got %0b want 0", toggle_err); end
        high(4);
        toggle_low();
        exp_cnt++;
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL gap_next_done got %0b want 1", frame_done); end
        checks++; if (frame_len !== 4'd5) begin errors++; $display("FAIL gap_next_len got %0d want 5", frame_len); end
        checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL gap_next_len_err got %0b want 0", len_err); end
        step(1'b0, f_lvl);
        checks++; if (seen_gap != 1) begin errors++; $display("FAIL gap_pulses got %0d want 1", seen_gap); end
        checks++; if (frame_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL gap_frame_cnt got %0d want %0d", frame_cnt, exp_cnt); end
    endtask

    task automatic test_mid_reset();
        high(2);
        rst = 1'b1;
        step(1'b1, 1'b0);
        checks++; if ({frame_done, len_err, toggle_err, gap_err, ovf_err, locked} !== 6'b0) begin
            errors++; $display("FAIL mreset_flags got %b want 000000", {frame_done, len_err, toggle_err, gap_err, ovf_err, locked});
        end
        checks++; if (frame_len !== 4'd0) begin errors++; $display("FAIL mreset_len got %0d want 0", frame_len); end
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL mreset_cnt got %0d want 0", frame_cnt); end
        rst = 1'b0;
        exp_cnt = 0;
        clear_seen();
        high(5);
        toggle_low();
        exp_cnt++;
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL mreset_done got %0b want 1", frame_done); end
        checks++; if (frame_len !== 4'd5) begin errors++; $display("FAIL mreset_frame_len got %0d want 5", frame_len); end
        checks++; if (frame_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL mreset_frame_cnt got %0d want %0d", frame_cnt, exp_cnt); end
        step(1'b0, f_lvl);
        checks++; if (seen_tog + seen_len != 0) begin errors++; $display("FAIL mreset_err_pulses got %0d want 0", seen_tog + seen_len); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_len_err();
        test_toggle_err();
        test_overflow();
        test_gap_err();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
